vec_mem_ctrl: RTL and testbench

VEC_MEM_CTRL -- requirements
Module: vec_mem_ctrl

---
 rtl/vec_mem_pkg.sv | 16 +
 rtl/vec_bank_ram.sv | 41 ++++
 rtl/vec_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_vec_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared defaults, MMIO register offsets and lane slicing for the vector memory controller.
package vec_mem_pkg;

  localparam int LANES_DEF  = 16;
  localparam int ELEM_W_DEF = 8;
  localparam int ADDR_W_DEF = 15;

  localparam int MMIO_LED_OFF = 0;
  localparam int MMIO_SW_OFF  = 1;

  // Bit offset of a lane inside a packed vector word.
  function automatic int lane_lsb(input int lane, input int elem_w);
    return lane * elem_w;
  endfunction

endpackage

// File: rtl/vec_bank_ram.sv
// True dual-port word RAM built as one bank per lane, so each lane has its own write enable.
module vec_bank_ram
  import vec_mem_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    i_a_en,
  input  logic [LANES-1:0]        i_a_be,
  input  logic [ADDR_W-1:0]       i_a_addr,
  input  logic [LANES*ELEM_W-1:0] i_a_wdata,
  output logic [LANES*ELEM_W-1:0] o_a_rdata,
  input  logic                    i_b_en,
  input  logic [LANES-1:0]        i_b_be,
  input  logic [ADDR_W-1:0]       i_b_addr,
  input  logic [LANES*ELEM_W-1:0] i_b_wdata,
  output logic [LANES*ELEM_W-1:0] o_b_rdata
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int LSB = lane_lsb(g, ELEM_W);

    logic [ELEM_W-1:0] r_mem [2**ADDR_W];
    logic [ELEM_W-1:0] r_a_q;
    logic [ELEM_W-1:0] r_b_q;

    // The controller never lets both ports touch the same word in one cycle.
    always_ff @(posedge clk) begin
      if (i_a_be[g]) r_mem[i_a_addr] <= i_a_wdata[LSB +: ELEM_W];
      if (i_b_be[g]) r_mem[i_b_addr] <= i_b_wdata[LSB +: ELEM_W];
      if (i_a_en)    r_a_q <= r_mem[i_a_addr];
      if (i_b_en)    r_b_q <= r_mem[i_b_addr];
    end

    assign o_a_rdata[LSB +: ELEM_W] = r_a_q;
    assign o_b_rdata[LSB +: ELEM_W] = r_b_q;
  end

endmodule

// File: rtl/vec_mem_ctrl.sv
// Scalar/vector memory front end: shared lane-banked RAM, scalar priority on word conflicts,
// and a small MMIO space holding the LED register and synchronised board switches.
module vec_mem_ctrl
  import vec_mem_pkg::*;
#(
  parameter  int LANES   = LANES_DEF,
  parameter  int ELEM_W  = ELEM_W_DEF,
  parameter  int ADDR_W  = ADDR_W_DEF,
  localparam int LANE_W  = $clog2(LANES),
  localparam int SADDR_W = ADDR_W + LANE_W + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_req,
  input  logic                    s_we,
  input  logic [SADDR_W-1:0]      s_addr,
  input  logic [ELEM_W-1:0]       s_wdata,
  input  logic                    s_signed,
  output logic [31:0]             s_rdata,
  output logic                    s_rvalid,
  input  logic                    v_req,
  input  logic                    v_we,
  input  logic [ADDR_W-1:0]       v_addr,
  input  logic [LANES*ELEM_W-1:0] v_wdata,
  input  logic [LANES-1:0]        v_mask,
  output logic                    v_ready,
  output logic [LANES*ELEM_W-1:0] v_rdata,
  output logic                    v_rvalid,
  output logic [7:0]              leds,
  input  logic [2:0]              switches
);

  logic                    w_s_mmio;
  logic [ADDR_W-1:0]       w_s_word;
  logic [LANE_W-1:0]       w_s_lane;
  logic [SADDR_W-2:0]      w_mmio_off;
  logic                    w_s_ram;
  logic                    w_conflict;
  logic                    w_v_go;
  logic [LANES-1:0]        w_a_be;
  logic [LANES-1:0]        w_b_be;
  logic [LANES*ELEM_W-1:0] w_a_q;
  logic [LANES*ELEM_W-1:0] w_b_q;
  logic [31:0]             w_mmio_rd;
  logic [ELEM_W-1:0]       w_s_elem;
  logic [31:0]             w_s_ext;

  logic                    r_s_rvalid;
  logic                    r_s_mmio;
  logic                    r_s_signed;
  logic [LANE_W-1:0]       r_s_lane;
  logic [31:0]             r_mmio_rdata;
  logic                    r_v_rvalid;
  logic [7:0]              r_leds;
  logic [2:0]              r_sw_meta;
  logic [2:0]              r_sw_sync;

  assign w_s_mmio   = s_addr[SADDR_W-1];
  assign w_s_word   = s_addr[LANE_W +: ADDR_W];
  assign w_s_lane   = s_addr[LANE_W-1:0];
  assign w_mmio_off = s_addr[SADDR_W-2:0];
  assign w_s_ram    = s_req & ~w_s_mmio;

  // MMIO traffic never reaches the RAM, so it cannot stall the vector port.
  assign w_conflict = w_s_ram & v_req & (w_s_word == v_addr) & (s_we | v_we);
  assign v_ready    = ~w_conflict;
  assign w_v_go     = v_req & ~w_conflict;

  assign w_a_be = (w_s_ram & s_we) ? (LANES'(1) << w_s_lane) : '0;
  assign w_b_be = (w_v_go & v_we) ? v_mask : '0;

  vec_bank_ram #(
    .LANES (LANES),
    .ELEM_W(ELEM_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk      (clk),
    .i_a_en   (w_s_ram & ~s_we),
    .i_a_be   (w_a_be),
    .i_a_addr (w_s_word),
    .i_a_wdata({LANES{s_wdata}}),
    .o_a_rdata(w_a_q),
    .i_b_en   (w_v_go & ~v_we),
    .i_b_be   (w_b_be),
    .i_b_addr (v_addr),
    .i_b_wdata(v_wdata),
    .o_b_rdata(w_b_q)
  );

  always_comb begin
    w_mmio_rd = '0;
    if (w_mmio_off == (SADDR_W-1)'(MMIO_LED_OFF)) w_mmio_rd = {24'b0, r_leds};
    else if (w_mmio_off == (SADDR_W-1)'(MMIO_SW_OFF)) w_mmio_rd = {29'b0, r_sw_sync};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s_rvalid   <= 1'b0;
      r_s_mmio     <= 1'b0;
      r_s_signed   <= 1'b0;
      r_s_lane     <= '0;
      r_mmio_rdata <= '0;
      r_v_rvalid   <= 1'b0;
      r_leds       <= '0;
      r_sw_meta    <= '0;
      r_sw_sync    <= '0;
    end else begin
      r_sw_meta  <= switches;
      r_sw_sync  <= r_sw_meta;
      r_s_rvalid <= s_req & ~s_we;
      r_v_rvalid <= w_v_go & ~v_we;
      if (s_req & ~s_we) begin
        r_s_mmio     <= w_s_mmio;
        r_s_signed   <= s_signed;
        r_s_lane     <= w_s_lane;
        r_mmio_rdata <= w_mmio_rd;
      end
      if (s_req & s_we & w_s_mmio & (w_mmio_off == (SADDR_W-1)'(MMIO_LED_OFF)))
        r_leds <= 8'(s_wdata);
    end
  end

  // Extension happens after the RAM's registered read; outputs are gated so reset clears them.
  assign w_s_elem = w_a_q[lane_lsb(int'(r_s_lane), ELEM_W) +: ELEM_W];
  assign w_s_ext  = r_s_signed ? 32'(signed'(w_s_elem)) : 32'(w_s_elem);

  assign s_rvalid = r_s_rvalid;
  assign s_rdata  = r_s_rvalid ? (r_s_mmio ? r_mmio_rdata : w_s_ext) : '0;
  assign v_rvalid = r_v_rvalid;
  assign v_rdata  = r_v_rvalid ? w_b_q : '0;
  assign leds     = r_leds;

endmodule

// File: tb/tb_vec_mem_ctrl.sv
// Directed table-driven bench for vec_mem_ctrl plus hand sequences for conflict, synchroniser and reset.
module tb_vec_mem_ctrl;

  logic         clk;
  logic         reset;
  logic         s_req, s_we, s_signed;
  logic [19:0]  s_addr;
  logic [7:0]   s_wdata;
  logic [31:0]  s_rdata;
  logic         s_rvalid;
  logic         v_req, v_we;
  logic [14:0]  v_addr;
  logic [127:0] v_wdata;
  logic [15:0]  v_mask;
  logic         v_ready;
  logic [127:0] v_rdata;
  logic         v_rvalid;
  logic [7:0]   leds;
  logic [2:0]   switches;

  int checks = 0;
  int errors = 0;

  vec_mem_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .s_req   (s_req),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_signed(s_signed),
    .s_rdata (s_rdata),
    .s_rvalid(s_rvalid),
    .v_req   (v_req),
    .v_we    (v_we),
    .v_addr  (v_addr),
    .v_wdata (v_wdata),
    .v_mask  (v_mask),
    .v_ready (v_ready),
    .v_rdata (v_rdata),
    .v_rvalid(v_rvalid),
    .leds    (leds),
    .switches(switches)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic         s_req, s_we, s_signed;
    logic [19:0]  s_addr;
    logic [7:0]   s_wdata;
    logic         v_req, v_we;
    logic [14:0]  v_addr;
    logic [127:0] v_wdata;
    logic [15:0]  v_mask;
    logic         e_s_rvalid;
    logic [31:0]  e_s_rdata;
    logic         e_v_rvalid;
    logic [127:0] e_v_rdata;
    logic [7:0]   e_leds;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  function automatic logic [19:0] sa(input logic m, input logic [14:0] w, input logic [3:0] l);
    return {m, w, l};
  endfunction

  function automatic vec_t mk(
    input logic sreq, input logic swe, input logic [19:0] saddr, input logic [7:0] swd,
    input logic ssg, input logic vreq, input logic vwe, input logic [14:0] vaddr,
    input logic [127:0] vwd, input logic [15:0] vmask, input logic esv, input logic [31:0] esd,
    input logic evv, input logic [127:0] evd, input logic [7:0] eled);
    vec_t t;
    t.s_req = sreq;  t.s_we = swe;  t.s_addr = saddr;  t.s_wdata = swd;  t.s_signed = ssg;
    t.v_req = vreq;  t.v_we = vwe;  t.v_addr = vaddr;  t.v_wdata = vwd;  t.v_mask = vmask;
    t.e_s_rvalid = esv;  t.e_s_rdata = esd;  t.e_v_rvalid = evv;  t.e_v_rdata = evd;
    t.e_leds = eled;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; s_signed = 1'b0;
    v_req = 1'b0; v_we = 1'b0; v_addr = '0; v_wdata = '0; v_mask = '0;
  endtask

  task automatic apply(input vec_t t);
    s_req = t.s_req; s_we = t.s_we; s_addr = t.s_addr; s_wdata = t.s_wdata; s_signed = t.s_signed;
    v_req = t.v_req; v_we = t.v_we; v_addr = t.v_addr; v_wdata = t.v_wdata; v_mask = t.v_mask;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [127:0] ramp, r11, raa, rff, r22, r01, r55, m9, w7;

  initial begin
    ramp = 128'h0F0E0D0C0B0A09080706050403020100;
    r11  = {16{8'h11}};
    raa  = {16{8'hAA}};
    rff  = {16{8'hFF}};
    r22  = {16{8'h22}};
    r01  = {16{8'h01}};
    r55  = {16{8'h55}};
    m9   = {{15{8'h11}}, 8'hAA};
    w7   = {{13{8'h01}}, 8'h9C, 8'h01, 8'h01};

    tbl[0]  = mk(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 15'd5, ramp, 16'hFFFF, 1'b0, '0, 1'b0, '0, 8'h00);
    tbl[1]  = mk(1'b1, 1'b0, sa(1'b0, 15'd5, 4'd3), '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h3, 1'b0, '0, 8'h00);
    tbl[2]  = mk(1'b1, 1'b0, sa(1'b0, 15'd5, 4'd15), '0, 1'b1, 1'b1, 1'b0, 15'd5, '0, '0, 1'b1, 32'hF, 1'b1, ramp, 8'h00);
    tbl[3]  = mk(1'b1, 1'b1, sa(1'b0, 15'd2, 4'd0), 8'h80, 1'b0, 1'b1, 1'b1, 15'd9, r11, 16'hFFFF, 1'b0, '0, 1'b0, '0, 8'h00);
    tbl[4]  = mk(1'b1, 1'b0, sa(1'b0, 15'd2, 4'd0), '0, 1'b1, 1'b1, 1'b0, 15'd9, '0, '0, 1'b1, 32'hFFFFFF80, 1'b1, r11, 8'h00);
    tbl[5]  = mk(1'b1, 1'b0, sa(1'b0, 15'd2, 4'd0), '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h80, 1'b0, '0, 8'h00);
    tbl[6]  = mk(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 15'd9, raa, 16'h0001, 1'b0, '0, 1'b0, '0, 8'h00);
    tbl[7]  = mk(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 15'd9, '0, '0, 1'b0, '0, 1'b1, m9, 8'h00);
    tbl[8]  = mk(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 15'd9, rff, 16'h0000, 1'b0, '0, 1'b0, '0, 8'h00);
    tbl[9]  = mk(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 15'd9, '0, '0, 1'b0, '0, 1'b1, m9, 8'h00);
    tbl[10] = mk(1'b1, 1'b1, sa(1'b1, 15'd0, 4'd0), 8'h5A, 1'b0, 1'b1, 1'b1, 15'd0, r22, 16'hFFFF, 1'b0, '0, 1'b0, '0, 8'h5A);
    tbl[11] = mk(1'b1, 1'b0, sa(1'b1, 15'd0, 4'd0), '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h5A, 1'b0, '0, 8'h5A);
    tbl[12] = mk(1'b1, 1'b1, sa(1'b1, 15'd0, 4'd7), 8'h77, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 8'h5A);
    tbl[13] = mk(1'b1, 1'b1, sa(1'b1, 15'd0, 4'd1), 8'h33, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 8'h5A);
    tbl[14] = mk(1'b1, 1'b0, sa(1'b1, 15'd0, 4'd7), '0, 1'b0, 1'b1, 1'b0, 15'd0, '0, '0, 1'b1, 32'h0, 1'b1, r22, 8'h5A);
    tbl[15] = mk(1'b1, 1'b0, sa(1'b1, 15'd0, 4'd1), '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h0, 1'b0, '0, 8'h5A);

    reset = 1'b0;
    switches = 3'b000;
    idle();
    #2;
    chk("rst_s_rvalid", s_rvalid, 1'b0);
    chk("rst_s_rdata", s_rdata, 32'h0);
    chk("rst_v_rvalid", v_rvalid, 1'b0);
    chk("rst_v_rdata", v_rdata, '0);
    chk("rst_v_ready", v_ready, 1'b1);
    chk("rst_leds", leds, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("row%0d_v_ready", i), v_ready, 1'b1);
      step();
      chk($sformatf("row%0d_s_rvalid", i), s_rvalid, tbl[i].e_s_rvalid);
      if (tbl[i].e_s_rvalid) chk($sformatf("row%0d_s_rdata", i), s_rdata, tbl[i].e_s_rdata);
      chk($sformatf("row%0d_v_rvalid", i), v_rvalid, tbl[i].e_v_rvalid);
      if (tbl[i].e_v_rvalid) chk($sformatf("row%0d_v_rdata", i), v_rdata, tbl[i].e_v_rdata);
      chk($sformatf("row%0d_leds", i), leds, tbl[i].e_leds);
    end
    idle();

    // Scalar write vs vector read to the same word: vector stalls one cycle, then sees the new lane.
    v_req = 1'b1; v_we = 1'b1; v_addr = 15'd7; v_wdata = r01; v_mask = 16'hFFFF;
    step();
    s_req = 1'b1; s_we = 1'b1; s_addr = sa(1'b0, 15'd7, 4'd2); s_wdata = 8'h9C;
    v_we = 1'b0; v_wdata = '0; v_mask = '0;
    #1;
    chk("cf_wr_v_ready_low", v_ready, 1'b0);
    step();
    chk("cf_wr_no_early_rvalid", v_rvalid, 1'b0);
    s_req = 1'b0; s_we = 1'b0;
    #1;
    chk("cf_wr_v_ready_high", v_ready, 1'b1);
    step();
    chk("cf_wr_v_rvalid", v_rvalid, 1'b1);
    chk("cf_wr_v_rdata", v_rdata, w7);
    idle();

    // Scalar read vs vector write to the same word: scalar reads old data, vector write follows.
    s_req = 1'b1; s_addr = sa(1'b0, 15'd7, 4'd2); s_signed = 1'b1;
    v_req = 1'b1; v_we = 1'b1; v_addr = 15'd7; v_wdata = r55; v_mask = 16'hFFFF;
    #1;
    chk("cf_rd_v_ready_low", v_ready, 1'b0);
    step();
    chk("cf_rd_s_rvalid", s_rvalid, 1'b1);
    chk("cf_rd_s_rdata", s_rdata, 32'hFFFFFF9C);
    s_req = 1'b0;
    #1;
    chk("cf_rd_v_ready_high", v_ready, 1'b1);
    step();
    v_we = 1'b0; v_wdata = '0; v_mask = '0;
    step();
    chk("cf_rd_v_rdata", v_rdata, r55);
    idle();

    // Switch change must not reach the MMIO read path until two clocks have passed.
    switches = 3'b101;
    s_req = 1'b1; s_addr = sa(1'b1, 15'd0, 4'd1);
    step();
    chk("sw_edge1", s_rdata, 32'h0);
    step();
    chk("sw_edge2", s_rdata, 32'h0);
    step();
    chk("sw_edge3_rvalid", s_rvalid, 1'b1);
    chk("sw_edge3", s_rdata, 32'h5);
    idle();
    step();

    // Reset during the read's response cycle.
    s_req = 1'b1; s_addr = sa(1'b0, 15'd5, 4'd3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    #1;
    chk("rst_mid_s_rvalid", s_rvalid, 1'b0);
    chk("rst_mid_s_rdata", s_rdata, 32'h0);
    chk("rst_mid_leds", leds, 8'h00);
    chk("rst_mid_v_ready", v_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rst_after1_s_rvalid", s_rvalid, 1'b0);
    step();
    chk("rst_after2_s_rvalid", s_rvalid, 1'b0);
    chk("rst_after_leds", leds, 8'h00);
    s_req = 1'b1; s_addr = sa(1'b0, 15'd5, 4'd3);
    step();
    chk("ram_kept_s_rvalid", s_rvalid, 1'b1);
    chk("ram_kept_s_rdata", s_rdata, 32'h3);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
